// File: rtl/axi_video_wr_burst.sv
`default_nettype none
// ============================================================================
//  Module   : axi_video_wr_burst
//  Purpose  : Drains one frame of pixel beats from the prefetch FIFO read port
//             and writes them to DDR as AXI4 INCR bursts, one burst in flight.
//  Revision : 1.0
// ============================================================================
module axi_video_wr_burst #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 28,
   parameter int BURST_LEN  = 16,
   parameter int CNT_WIDTH  = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_start,
   input  logic [ADDR_WIDTH-1:0]   frame_base,
   input  logic [CNT_WIDTH-1:0]    frame_beats,
   input  logic [DATA_WIDTH-1:0]   fifo_data,
   input  logic                    fifo_vld,
   output logic                    fifo_rd_en,
   output logic [ADDR_WIDTH-1:0]   axi_awaddr,
   output logic [7:0]              axi_awlen,
   output logic [2:0]              axi_awsize,
   output logic [1:0]              axi_awburst,
   output logic                    axi_awvalid,
   input  logic                    axi_awready,
   output logic [DATA_WIDTH-1:0]   axi_wdata,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb,
   output logic                    axi_wlast,
   output logic                    axi_wvalid,
   input  logic                    axi_wready,
   input  logic [1:0]              axi_bresp,
   input  logic                    axi_bvalid,
   output logic                    axi_bready,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    wr_err
);

   localparam int         c_BYTES   = DATA_WIDTH / 8;
   localparam logic [2:0] c_AWSIZE  = 3'($clog2(c_BYTES));
   localparam logic [7:0] c_MAX_LEN = 8'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CNT_WIDTH-1:0]  r_remain;
   logic [7:0]            r_awlen;
   logic [7:0]            r_beat_cnt;
   logic                  r_aw_arm;
   logic                  r_frame_done;
   logic                  r_wr_err;
   logic [8:0]            w_blen;
   logic [CNT_WIDTH-1:0]  w_remain_nxt;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_b_hs;
   logic                  w_last;

   assign w_blen       = {1'b0, r_awlen} + 9'd1;
   assign w_remain_nxt = r_remain - CNT_WIDTH'(w_blen);
   assign w_aw_hs      = (r_state == S_ADDR) && r_aw_arm && axi_awready;
   assign w_w_hs       = (r_state == S_DATA) && fifo_vld && axi_wready;
   assign w_b_hs       = (r_state == S_RESP) && axi_bvalid;
   assign w_last       = (r_state == S_DATA) && (r_beat_cnt == r_awlen);

   assign axi_awaddr  = r_addr;
   assign axi_awlen   = r_awlen;
   assign axi_awsize  = c_AWSIZE;
   assign axi_awburst = 2'b01;
   assign axi_wdata   = fifo_data;
   assign axi_wstrb   = '1;
   assign frame_done  = r_frame_done;
   assign wr_err      = r_wr_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      axi_wlast   = 1'b0;
      fifo_rd_en  = 1'b0;
      axi_bready  = 1'b0;
      busy        = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (frame_start && (frame_beats != '0)) w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            axi_awvalid = r_aw_arm;
            if (w_aw_hs) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            // Data is never presented without a FIFO beat behind it.
            axi_wvalid = fifo_vld;
            fifo_rd_en = axi_wready;
            axi_wlast  = w_last;
            if (w_w_hs && w_last) w_state_nxt = S_RESP;
         end
         S_RESP: begin
            axi_bready = 1'b1;
            if (w_b_hs) w_state_nxt = (w_remain_nxt == '0) ? S_IDLE : S_ADDR;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr       <= '0;
         r_remain     <= '0;
         r_awlen      <= '0;
         r_beat_cnt   <= '0;
         r_aw_arm     <= 1'b0;
         r_frame_done <= 1'b0;
         r_wr_err     <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_addr       <= frame_base;
                  r_remain     <= frame_beats;
                  r_wr_err     <= 1'b0;
                  r_frame_done <= (frame_beats == '0);
               end
            end
            S_ADDR: begin
               // First ADDR cycle sizes the burst; AW is offered from the next.
               if (!r_aw_arm) begin
                  r_aw_arm <= 1'b1;
                  r_awlen  <= (r_remain >= CNT_WIDTH'(BURST_LEN)) ? c_MAX_LEN
                                                                  : r_remain[7:0] - 8'd1;
               end else if (axi_awready) begin
                  r_aw_arm   <= 1'b0;
                  r_beat_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_w_hs) r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            S_RESP: begin
               if (axi_bvalid) begin
                  if (axi_bresp != 2'b00) r_wr_err <= 1'b1;
                  r_addr       <= r_addr + (ADDR_WIDTH'(w_blen) << c_AWSIZE);
                  r_remain     <= w_remain_nxt;
                  r_frame_done <= (w_remain_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_video_wr_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_video_wr_burst
//  Purpose  : Scoreboard bench for axi_video_wr_burst with a frame-level model.
//  Revision : 1.0
// ============================================================================
module tb_axi_video_wr_burst;

   localparam int AW = 28;
   localparam int DW = 256;
   localparam int CW = 24;
   localparam int BL = 16;
   localparam int BYTES = DW / 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           frame_start;
   logic [AW-1:0]  frame_base;
   logic [CW-1:0]  frame_beats;
   logic [DW-1:0]  fifo_data;
   logic           fifo_vld;
   logic           fifo_rd_en;
   logic [AW-1:0]  axi_awaddr;
   logic [7:0]     axi_awlen;
   logic [2:0]     axi_awsize;
   logic [1:0]     axi_awburst;
   logic           axi_awvalid;
   logic           axi_awready;
   logic [DW-1:0]  axi_wdata;
   logic [DW/8-1:0] axi_wstrb;
   logic           axi_wlast;
   logic           axi_wvalid;
   logic           axi_wready;
   logic [1:0]     axi_bresp;
   logic           axi_bvalid;
   logic           axi_bready;
   logic           busy;
   logic           frame_done;
   logic           wr_err;

   always #5 clk = ~clk;

   axi_video_wr_burst dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .frame_base(frame_base),
      .frame_beats(frame_beats), .fifo_data(fifo_data), .fifo_vld(fifo_vld),
      .fifo_rd_en(fifo_rd_en), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .busy(busy), .frame_done(frame_done), .wr_err(wr_err)
   );

   typedef struct { logic [AW-1:0] addr; logic [7:0] len; bit last; } aw_t;
   typedef struct { logic [DW-1:0] data; bit last; } w_t;

   aw_t aw_q[$];
   aw_t resp_q[$];
   aw_t aw_log[$];
   w_t  w_q[$];
   int  wlast_log[$];

   int checks = 0;
   int errors = 0;
   int fifo_idx = 0;
   int model_word = 0;
   bit pop_pend = 1'b0;
   int w_frame_cnt = 0;
   int b_frame_cnt = 0;
   int done_cnt = 0;
   int err_burst = -1;
   int cyc = 0;
   bit exp_done = 1'b0;
   bit exp_err = 1'b0;
   bit toggle_vld = 1'b0;
   bit stall_req = 1'b0;
   int hold_aw = 0;
   int w_stall = 0;
   int p_vld = 100, p_aw = 100, p_w = 100, p_b = 100;

   function automatic logic [DW-1:0] word(int i);
      logic [DW-1:0] w;
      for (int k = 0; k < DW / 32; k++)
         w[k*32 +: 32] = (i * 32'h01000193) ^ (k * 32'h9E3779B9) ^ 32'h5A5A0000;
      return w;
   endfunction

   function automatic bit rnd(int p);
      return $urandom_range(99, 0) < p;
   endfunction

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected bursts and beats for a whole frame, from the burst-splitting rule.
   task automatic model_frame(logic [AW-1:0] base, int beats);
      logic [AW-1:0] a;
      int rem;
      int bl;
      a = base;
      rem = beats;
      while (rem > 0) begin
         bl = (rem < BL) ? rem : BL;
         aw_q.push_back('{a, 8'(bl - 1), rem == bl});
         for (int j = 0; j < bl; j++) begin
            w_q.push_back('{word(model_word), j == bl - 1});
            model_word++;
         end
         a = a + AW'(bl * BYTES);
         rem -= bl;
      end
   endtask

   initial begin : monitor
      logic [AW-1:0] pa;
      logic [7:0]    pl;
      bit            pw;
      aw_t           e;
      w_t            ew;
      pw = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            aw_q.delete(); w_q.delete(); resp_q.delete();
            exp_done = 1'b0; exp_err = 1'b0; pw = 1'b0;
            model_word = fifo_idx;
         end else begin
            chk("frame_done", frame_done, exp_done);
            chk("wr_err", wr_err, exp_err);
            if (frame_done) done_cnt++;
            exp_done = 1'b0;
            if (pw) chk("aw_hold", {axi_awvalid, axi_awaddr, axi_awlen}, {1'b1, pa, pl});
            pw = axi_awvalid && !axi_awready;
            pa = axi_awaddr;
            pl = axi_awlen;
            if (!fifo_vld)   chk("wvalid_no_data", axi_wvalid, 1'b0);
            if (!axi_wready) chk("pop_while_stalled", fifo_rd_en, 1'b0);
            if (fifo_vld && fifo_rd_en) pop_pend = 1'b1;
            if (frame_start && !busy) begin
               model_frame(frame_base, int'(frame_beats));
               exp_err = 1'b0;
               w_frame_cnt = 0;
               b_frame_cnt = 0;
               aw_log.delete();
               wlast_log.delete();
               if (frame_beats == '0) exp_done = 1'b1;
            end
            if (axi_awvalid && axi_awready) begin
               aw_log.push_back('{axi_awaddr, axi_awlen, 1'b0});
               if (aw_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL aw_unexpected actual addr=%0h len=%0d required=no burst", axi_awaddr, axi_awlen);
               end else begin
                  e = aw_q.pop_front();
                  chk("awaddr", axi_awaddr, e.addr);
                  chk("awlen", axi_awlen, e.len);
                  resp_q.push_back(e);
               end
            end
            if (axi_wvalid && axi_wready) begin
               w_frame_cnt++;
               if (axi_wlast) wlast_log.push_back(w_frame_cnt);
               if (w_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL w_unexpected actual beat=%0h required=no beat", axi_wdata);
               end else begin
                  ew = w_q.pop_front();
                  chk("wdata", axi_wdata, ew.data);
                  chk("wlast", axi_wlast, ew.last);
               end
            end
            if (axi_bvalid && axi_bready) begin
               b_frame_cnt++;
               if (axi_bresp != 2'b00) exp_err = 1'b1;
               if (resp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL b_unexpected actual=response required=no response");
               end else begin
                  e = resp_q.pop_front();
                  if (e.last) exp_done = 1'b1;
               end
            end
         end
      end
   end

   initial begin : driver
      forever begin
         @(posedge clk);
         #1;
         if (pop_pend) begin
            fifo_idx++;
            pop_pend = 1'b0;
         end
         fifo_data   = word(fifo_idx);
         fifo_vld    = toggle_vld ? cyc[0] : rnd(p_vld);
         axi_awready = (hold_aw > 0) ? 1'b0 : rnd(p_aw);
         if (hold_aw > 0) hold_aw--;
         if (stall_req && w_frame_cnt == 2) begin
            w_stall = 4;
            stall_req = 1'b0;
         end
         axi_wready = (w_stall > 0) ? 1'b0 : rnd(p_w);
         if (w_stall > 0) w_stall--;
         axi_bvalid = rnd(p_b);
         axi_bresp  = (b_frame_cnt == err_burst) ? 2'b10 : 2'b00;
      end
   end

   task automatic start_frame(logic [AW-1:0] base, int beats);
      @(posedge clk);
      #1;
      done_cnt    = 0;
      frame_start = 1'b1;
      frame_base  = base;
      frame_beats = CW'(beats);
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic wait_frame(int bound);
      int n;
      bit idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < bound) begin
         @(negedge clk);
         #2;
         n++;
         idle = !busy && aw_q.size() == 0 && w_q.size() == 0 && resp_q.size() == 0 && !exp_done;
      end
      if (!idle) begin
         checks++; errors++;
         $display("FAIL frame_timeout actual=%0d cycles required=completion", n);
      end
   endtask

   task automatic chk_quiet_outputs();
      chk("rst_awvalid", axi_awvalid, 1'b0);
      chk("rst_wvalid", axi_wvalid, 1'b0);
      chk("rst_wlast", axi_wlast, 1'b0);
      chk("rst_bready", axi_bready, 1'b0);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_wr_err", wr_err, 1'b0);
      chk("rst_awaddr", axi_awaddr, '0);
      chk("rst_awlen", axi_awlen, '0);
   endtask

   initial begin : main
      rst = 1'b1; frame_start = 1'b0; frame_base = '0; frame_beats = '0;
      fifo_data = '0; fifo_vld = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
      axi_bresp = 2'b00; axi_bvalid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_quiet_outputs();
      chk("awsize", axi_awsize, 3'd5);
      chk("awburst", axi_awburst, 2'b01);
      chk("wstrb", axi_wstrb, {(DW/8){1'b1}});
      @(posedge clk);
      #1 rst = 1'b0;

      // 40-beat frame, everything always ready
      start_frame(28'h0100000, 40);
      wait_frame(2000);
      chk("t1_bursts", aw_log.size(), 3);
      if (aw_log.size() == 3) begin
         chk("t1_addr0", aw_log[0].addr, 28'h0100000); chk("t1_len0", aw_log[0].len, 8'd15);
         chk("t1_addr1", aw_log[1].addr, 28'h0100200); chk("t1_len1", aw_log[1].len, 8'd15);
         chk("t1_addr2", aw_log[2].addr, 28'h0100400); chk("t1_len2", aw_log[2].len, 8'd7);
      end
      chk("t1_wlasts", wlast_log.size(), 3);
      if (wlast_log.size() == 3) begin
         chk("t1_wlast0", wlast_log[0], 16);
         chk("t1_wlast1", wlast_log[1], 32);
         chk("t1_wlast2", wlast_log[2], 40);
      end
      chk("t1_done", done_cnt, 1);

      // FIFO valid toggling every cycle
      toggle_vld = 1'b1;
      start_frame(28'h0000000, 20);
      wait_frame(2000);
      toggle_vld = 1'b0;
      chk("t2_beats", w_frame_cnt, 20);
      chk("t2_wlasts", wlast_log.size(), 2);
      chk("t2_done", done_cnt, 1);

      // awready held off, then wready dropped at beat 3
      hold_aw = 7;
      stall_req = 1'b1;
      start_frame(28'h0004000, 16);
      wait_frame(2000);
      chk("t3_bursts", aw_log.size(), 1);
      chk("t3_beats", w_frame_cnt, 16);
      chk("t3_done", done_cnt, 1);

      // error response on the second of three bursts
      err_burst = 1;
      start_frame(28'h0008000, 40);
      wait_frame(2000);
      err_burst = -1;
      chk("t4_err", wr_err, 1'b1);
      chk("t4_bursts", aw_log.size(), 3);
      chk("t4_done", done_cnt, 1);

      // empty frame also clears the sticky error
      start_frame(28'h0000000, 0);
      wait_frame(100);
      chk("t5_err_clear", wr_err, 1'b0);
      chk("t5_bursts", aw_log.size(), 0);
      chk("t5_done", done_cnt, 1);

      // frame_start while busy is ignored
      start_frame(28'h000C000, 24);
      repeat (3) @(posedge clk);
      #1;
      frame_start = 1'b1; frame_base = 28'h0020000; frame_beats = CW'(5);
      @(posedge clk);
      #1 frame_start = 1'b0;
      wait_frame(2000);
      chk("t6_beats", w_frame_cnt, 24);
      chk("t6_bursts", aw_log.size(), 2);
      chk("t6_done", done_cnt, 1);

      // reset mid-burst, then a clean frame
      start_frame(28'h0010000, 40);
      begin
         int n;
         n = 0;
         while (w_frame_cnt < 5 && n < 500) begin
            @(negedge clk);
            n++;
         end
         chk("t7_reached_data", w_frame_cnt >= 5, 1'b1);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk_quiet_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      start_frame(28'h0002000, 10);
      wait_frame(2000);
      chk("t7_bursts", aw_log.size(), 1);
      if (aw_log.size() == 1) begin
         chk("t7_addr", aw_log[0].addr, 28'h0002000);
         chk("t7_len", aw_log[0].len, 8'd9);
      end
      chk("t7_beats", w_frame_cnt, 10);
      chk("t7_done", done_cnt, 1);

      // randomized frames, first one wraps the address space
      for (int f = 0; f < 10; f++) begin
         logic [AW-1:0] base;
         int beats;
         p_vld = $urandom_range(100, 30);
         p_aw  = $urandom_range(100, 30);
         p_w   = $urandom_range(100, 30);
         p_b   = $urandom_range(100, 30);
         err_burst = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 0)) : -1;
         base  = (f == 0) ? 28'hFFFFE00 : (AW'($urandom) & 28'hFFFFE00);
         beats = (f == 0) ? 40 : int'($urandom_range(70, 0));
         start_frame(base, beats);
         wait_frame(5000);
         chk("rnd_beats", w_frame_cnt, beats);
         chk("rnd_done", done_cnt, 1);
      end
      err_burst = -1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_video_wr_burst.md
Name: axi_video_wr_burst

Overview:
- Downstream consumer of the video prefetch FIFO read port, in the read-clock domain.
- Drains one frame of pixel beats from the FIFO and writes them to DDR as AXI4 INCR write bursts, starting at a programmable base address.
- Allows one outstanding burst at a time.
- Frame-level handshake: `frame_start` begins a frame; `frame_done` reports completion.

Parameters:
- DATA_WIDTH, 256, FIFO and AXI write data width in bits; power of 2, 32..512.
- ADDR_WIDTH, 28, AXI byte address width.
- BURST_LEN, 16, maximum beats per burst; power of 2, 1..256. BURST_LEN*DATA_WIDTH/8 must be ≤ 4096.
- CNT_WIDTH, 24, width of the frame beat counter.

Ports:
- clk  in  1  Clock. Also drives the FIFO read side.
- rst  in  1  Asynchronous reset, active-high.
- frame_start  in  1  Single-cycle pulse. Latches frame_base and frame_beats.
- frame_base  in  ADDR_WIDTH  Frame start byte address; aligned to BURST_LEN*DATA_WIDTH/8.
- frame_beats  in  CNT_WIDTH  Number of DATA_WIDTH beats in the frame.
- fifo_data  in  DATA_WIDTH  FIFO read data.
- fifo_vld  in  1  FIFO read data valid.
- fifo_rd_en  out  1  FIFO pop. A beat is consumed when fifo_vld & fifo_rd_en.
- axi_awaddr  out  ADDR_WIDTH  Burst address.
- axi_awlen  out  8  Beats minus 1.
- axi_awsize  out  3  Constant log2(DATA_WIDTH/8).
- axi_awburst  out  2  Constant 2'b01 (INCR).
- axi_awvalid  out  1  Write address valid.
- axi_awready  in  1  Write address ready.
- axi_wdata  out  DATA_WIDTH  Equal to fifo_data.
- axi_wstrb  out  DATA_WIDTH/8  All ones.
- axi_wlast  out  1  Last beat of the burst.
- axi_wvalid  out  1  Write data valid.
- axi_wready  in  1  Write data ready.
- axi_bresp  in  2  Write response code.
- axi_bvalid  in  1  Write response valid.
- axi_bready  out  1  Write response ready.
- busy  out  1  High whenever the FSM is not in IDLE.
- frame_done  out  1  One-cycle pulse when the frame is complete.
- wr_err  out  1  Sticky error flag; set when any bresp ≠ 2'b00.

Behaviour:
- Reset values:
  - All outputs 0, except the constant outputs axi_awsize, axi_awburst and axi_wstrb.
  - FSM = IDLE; all counters = 0.
  - Reset asserted mid-burst aborts the transfer immediately. No recovery of the partial burst.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On frame_start: latch addr ← frame_base and remain ← frame_beats; clear wr_err.
  - If frame_beats = 0: pulse frame_done on the next cycle and stay in IDLE.
  - Otherwise go to ADDR.
  - frame_start outside IDLE is ignored.
- ADDR:
  - Compute blen = min(BURST_LEN, remain), registered on entry.
  - Drive axi_awaddr = addr, axi_awlen = blen−1, axi_awvalid = 1.
  - Hold all AW outputs stable until axi_awready.
  - On the handshake: beat_cnt ← 0, go to DATA.
- DATA:
  - axi_wvalid = fifo_vld; fifo_rd_en = axi_wready; axi_wdata = fifo_data (combinational pass-through).
  - A beat transfers on fifo_vld & axi_wready. beat_cnt increments on each transfer.
  - axi_wlast = (beat_cnt == blen−1).
  - An empty FIFO stalls W with wvalid = 0. The block never drives wvalid without data.
  - On the wlast transfer: go to RESP.
- RESP:
  - axi_bready = 1.
  - On axi_bvalid:
    - If bresp ≠ 0, set wr_err.
    - addr ← addr + blen*DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
    - remain ← remain − blen.
    - If the new remain = 0: pulse frame_done, go to IDLE. Otherwise go to ADDR.
- Latency from IDLE:
  - frame_start to awvalid: 2 cycles (latch cycle, then blen register).
  - wlast handshake to bready: 1 cycle.
- A final partial burst uses awlen = remain−1.
- A burst never crosses 4 KB. This is guaranteed by the alignment rule on frame_base and the BURST_LEN parameter limit; no runtime check is performed.
- wr_err does not abort the frame; the remaining bursts still run.
- busy = (state ≠ IDLE).

Test Plan:
- DATA_WIDTH=256, BURST_LEN=16, frame_base=0x100000, frame_beats=40, FIFO always valid, slave always ready:
  - Required: three bursts at 0x100000 (awlen=15), 0x100200 (awlen=15), 0x100400 (awlen=7).
  - Wdata order matches FIFO order; wlast on beats 16, 32, 40; one frame_done pulse.
- fifo_vld toggling 1-0-1 within a burst: wvalid follows fifo_vld; no duplicate or dropped beats; beat count per burst is exact.
- awready held low for 5 cycles, then wready low on beat 3 for 4 cycles:
  - awaddr/awlen stay stable while awready is low.
  - FIFO is not popped while wready is low.
- bresp=2'b10 on the second burst of a 3-burst frame: wr_err=1 from that cycle; the third burst is still issued; frame_done pulses; next frame_start clears wr_err.
- frame_beats=0: frame_done pulses 1 cycle after frame_start; no AW activity. A frame_start during a busy frame is ignored: the frame completes with the original beat count.
- rst asserted in DATA mid-burst: all outputs and busy return to 0 immediately; a subsequent frame_start runs a clean frame from beat 0.
